// File: rtl/add5_pkg.sv
// add5_pkg: shared types and widths for the add5_arbiter slice.
//   state_t : arbiter FSM states (IDLE, CALC, DONE), 2-bit encoding
//   OPW     : operand width (5)
//   SUMW    : sum width including carry-out (6)
package add5_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned SUMW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add5_arbiter_if.sv
// add5_arbiter_if: bundle of both requesters' handshakes and the shared result.
//   req0/a0/b0, req1/a1/b1 : client requests and operands (client -> arbiter)
//   gnt[1:0]               : one-hot grant (arbiter -> client)
//   done[1:0]              : one-cycle result-valid pulse per requester
//   sum[5:0]               : registered {carry, sum}
//   busy                   : arbiter not idle
// Modports: master = client side, slave = arbiter side.
interface add5_arbiter_if;
    import add5_pkg::*;

    logic            req0;
    logic [OPW-1:0]  a0;
    logic [OPW-1:0]  b0;
    logic            req1;
    logic [OPW-1:0]  a1;
    logic [OPW-1:0]  b1;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [SUMW-1:0] sum;
    logic            busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt, done, sum, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt, done, sum, busy
    );

endinterface

// File: rtl/add5_rca.sv
// add5_rca: combinational 5-bit ripple-carry adder from half/full-adder cells.
//   x[4:0], y[4:0] : unsigned operands
//   s[5:0]         : {carry-out, 5-bit sum}
module add5_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module add5_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);
endmodule

module add5_rca
    import add5_pkg::*;
(
    input  logic [OPW-1:0]  x,
    input  logic [OPW-1:0]  y,
    output logic [SUMW-1:0] s
);
    // c[i] is the carry out of bit i; c[OPW-1] becomes the sum MSB.
    logic [OPW-1:0] c;

    add5_ha u_bit0 (
        .a (x[0]),
        .b (y[0]),
        .s (s[0]),
        .c (c[0])
    );

    for (genvar i = 1; i < OPW; i++) begin : g_fa
        add5_fa u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i-1]),
            .s  (s[i]),
            .co (c[i])
        );
    end

    assign s[SUMW-1] = c[OPW-1];

endmodule

// File: rtl/add5_arbiter.sv
// add5_arbiter: round-robin share of one 5-bit adder between two requesters.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : add5_arbiter_if.slave (requests/operands in, gnt/done/sum/busy out)
// Each transaction is IDLE -> CALC -> DONE -> IDLE; operands are latched on
// the grant edge, the sum is registered in CALC and done pulses for one cycle.
module add5_arbiter
    import add5_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    add5_arbiter_if.slave        bus
);

    state_t          state_q, state_n;
    logic [1:0]      gnt_q, gnt_n;
    logic [1:0]      done_q, done_n;
    logic [SUMW-1:0] sum_q, sum_n;
    logic [OPW-1:0]  opa_q, opa_n;
    logic [OPW-1:0]  opb_q, opb_n;
    logic            last_q, last_n;
    logic [SUMW-1:0] add_s;
    logic            winner;

    add5_rca u_rca (
        .x (opa_q),
        .y (opb_q),
        .s (add_s)
    );

    // On a tie the requester that was not served last wins; a lone request
    // always wins.
    assign winner = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            sum_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            done_q  <= done_n;
            sum_q   <= sum_n;
            opa_q   <= opa_n;
            opb_q   <= opb_n;
            last_q  <= last_n;
        end
    end

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        done_n  = done_q;
        sum_n   = sum_q;
        opa_n   = opa_q;
        opb_n   = opb_q;
        last_n  = last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    opa_n   = winner ? bus.a1 : bus.a0;
                    opb_n   = winner ? bus.b1 : bus.b0;
                    gnt_n   = winner ? 2'b10 : 2'b01;
                    state_n = CALC;
                end
            end
            CALC: begin
                sum_n   = add_s;
                done_n  = gnt_q;
                state_n = DONE;
            end
            DONE: begin
                gnt_n   = '0;
                done_n  = '0;
                last_n  = gnt_q[1];
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                done_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_add5_arbiter.sv
// tb_add5_arbiter: directed and randomized checks of add5_arbiter against a
// transaction-level model tracking grant age, last-served requester and the
// arithmetic result.
module tb_add5_arbiter;

    logic clk;
    logic rst_tb;

    add5_arbiter_if bus ();

    add5_arbiter dut (
        .clk   (clk),
        .reset (rst_tb),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_age;   // cycles since grant; 0 = no transaction in flight
    int m_who;   // requester being served
    int m_last;  // requester served most recently
    int m_res;   // a+b of the latched operands
    int m_gnt, m_done, m_sum;

    function automatic int pick(input int r0, input int r1, input int last);
        if (r0 != 0 && r1 != 0) return 1 - last;
        return (r1 != 0) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst_tb) begin
        if (rst_tb) begin
            m_age <= 0; m_who <= 0; m_last <= 1; m_res <= 0;
            m_gnt <= 0; m_done <= 0; m_sum <= 0;
        end else if (m_age == 0) begin
            if (bus.req0 || bus.req1) begin
                m_who <= pick(int'(bus.req0), int'(bus.req1), m_last);
                m_res <= (pick(int'(bus.req0), int'(bus.req1), m_last) == 1)
                         ? int'(bus.a1) + int'(bus.b1) : int'(bus.a0) + int'(bus.b0);
                m_gnt <= 1 << pick(int'(bus.req0), int'(bus.req1), m_last);
                m_age <= 1;
            end
        end else if (m_age == 1) begin
            m_sum  <= m_res;
            m_done <= 1 << m_who;
            m_age  <= 2;
        end else begin
            m_gnt  <= 0;
            m_done <= 0;
            m_last <= m_who;
            m_age  <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_tb) begin
            chk("gnt",  int'(bus.gnt),  m_gnt);
            chk("done", int'(bus.done), m_done);
            chk("sum",  int'(bus.sum),  m_sum);
            chk("busy", int'(bus.busy), (m_age != 0) ? 1 : 0);
            chk("onehot", (($countones(bus.gnt) <= 1) && ($countones(bus.done) <= 1)) ? 1 : 0, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_tb = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_tb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    endtask

    int pulse_d[$];
    int pulse_s[$];
    int pulse_t[$];
    int got;
    bit seen;

    initial begin
        idle_inputs();
        rst_tb = 1'b0;
        #1 rst_tb = 1'b1;
        #1;
        chk("rst_gnt",  int'(bus.gnt),  0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sum",  int'(bus.sum),  0);
        chk("rst_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_tb = 1'b0;
        step();

        // 31 + 31 through port 0
        bus.req0 = 1'b1; bus.a0 = 5'd31; bus.b0 = 5'd31;
        step();
        bus.req0 = 1'b0;
        chk("t1_gnt", int'(bus.gnt), 1);
        chk("t1_busy", int'(bus.busy), 1);
        step();
        chk("t1_done", int'(bus.done), 1);
        chk("t1_sum", int'(bus.sum), 62);
        chk("t1_model_sum", m_sum, 62);
        step();
        chk("t1_busy_low", int'(bus.busy), 0);
        chk("t1_gnt_low", int'(bus.gnt), 0);

        // Both requesters held: alternate starting with port 0
        do_reset();
        bus.a0 = 5'd3; bus.b0 = 5'd4; bus.a1 = 5'd10; bus.b1 = 5'd20;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.done != 2'b00) begin
                pulse_d.push_back(int'(bus.done));
                pulse_s.push_back(int'(bus.sum));
                pulse_t.push_back(c);
            end
        end
        idle_inputs();
        chk("alt_count_ge3", (pulse_d.size() >= 3) ? 1 : 0, 1);
        if (pulse_d.size() >= 3) begin
            chk("alt_d0", pulse_d[0], 1); chk("alt_s0", pulse_s[0], 7);
            chk("alt_d1", pulse_d[1], 2); chk("alt_s1", pulse_s[1], 30);
            chk("alt_d2", pulse_d[2], 1); chk("alt_s2", pulse_s[2], 7);
            chk("alt_gap", pulse_t[1] - pulse_t[0], 3);
        end
        repeat (4) step();

        // Operand change after grant is ignored
        do_reset();
        bus.req1 = 1'b1; bus.a1 = 5'd1; bus.b1 = 5'd2;
        step();
        chk("opchg_gnt", int'(bus.gnt), 2);
        bus.a1 = 5'd30; bus.req1 = 1'b0;
        step();
        chk("opchg_done", int'(bus.done), 2);
        chk("opchg_sum", int'(bus.sum), 3);
        step();

        // Reset in CALC discards the transaction
        bus.req0 = 1'b1; bus.a0 = 5'd9; bus.b0 = 5'd9;
        step();
        chk("rstmid_gnt_before", int'(bus.gnt), 1);
        bus.req0 = 1'b0;
        rst_tb = 1'b1;
        #1;
        chk("rstmid_gnt", int'(bus.gnt), 0);
        chk("rstmid_done", int'(bus.done), 0);
        chk("rstmid_sum", int'(bus.sum), 0);
        chk("rstmid_busy", int'(bus.busy), 0);
        @(negedge clk);
        #1 rst_tb = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.done != 2'b00) seen = 1;
        end
        chk("rstmid_no_done", int'(seen), 0);

        // Deassert req0 during CALC; FSM returns to IDLE and stays there
        bus.req0 = 1'b1; bus.a0 = 5'd17; bus.b0 = 5'd6;
        step();
        bus.req0 = 1'b0;
        step();
        chk("drop_done", int'(bus.done), 1);
        chk("drop_sum", int'(bus.sum), 23);
        step();
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.busy) seen = 1;
        end
        chk("drop_stays_idle", int'(seen), 0);

        // Exhaustive sweep through port 0
        for (int i = 0; i < 1024; i++) begin
            bus.req0 = 1'b1;
            bus.a0 = 5'(i >> 5);
            bus.b0 = 5'(i & 31);
            step();
            bus.req0 = 1'b0;
            seen = 0;
            got = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                step();
                if (bus.done[0]) begin
                    seen = 1;
                    got = int'(bus.sum);
                end
            end
            if (!seen) chk("sweep_timeout", 0, 1);
            else chk("sweep_sum", got, (i >> 5) + (i & 31));
            step();
        end

        // Random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 400; c++) begin
            bus.req0 = 1'($urandom_range(0, 1));
            bus.req1 = 1'($urandom_range(0, 1));
            bus.a0 = 5'($urandom); bus.b0 = 5'($urandom);
            bus.a1 = 5'($urandom); bus.b1 = 5'($urandom);
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
